// File: rtl/gate_result_checker.sv
// Self-checking stage behind the two-input gate array: compares sampled gate results
// against the truth table and accumulates errors, operand coverage and first-failure details.
module gate_result_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             sample_valid_in,
  input  logic             a_in,
  input  logic             b_in,
  input  logic [6:0]       y_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [CNT_W-1:0] err_count_out,
  output logic [CNT_W-1:0] sample_count_out,
  output logic [3:0]       coverage_out,
  output logic [1:0]       first_fail_vec_out,
  output logic [6:0]       first_fail_mask_out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_a_q, s1_a_d;
  logic             s1_b_q, s1_b_d;
  logic [6:0]       s1_y_q, s1_y_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic [1:0]       ff_vec_q, ff_vec_d;
  logic [6:0]       ff_mask_q, ff_mask_d;
  logic             pass_q, pass_d;

  logic       accept;
  logic       start_run;
  logic [6:0] expected;
  logic [6:0] mismatch;

  assign accept    = (state_q == RUN) && sample_valid_in;
  assign start_run = (state_q == IDLE) && start_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = RUN;
      RUN:     if (accept && (cnt_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (!s1_valid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit order matches the result bus: NOT a, XNOR, XOR, NOR, NAND, OR, AND
  assign expected = {~s1_a_q, ~(s1_a_q ^ s1_b_q), s1_a_q ^ s1_b_q, ~(s1_a_q | s1_b_q),
                     ~(s1_a_q & s1_b_q), s1_a_q | s1_b_q, s1_a_q & s1_b_q};
  assign mismatch = s1_y_q ^ expected;

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_y_d     = s1_y_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cov_d      = cov_q;
    ff_vec_d   = ff_vec_q;
    ff_mask_d  = ff_mask_q;
    pass_d     = pass_q;

    if (accept) begin
      s1_a_d = a_in;
      s1_b_d = b_in;
      s1_y_d = y_in;
      cnt_d  = cnt_q + CNT_W'(1);
    end

    if (start_run) begin
      err_d     = '0;
      cnt_d     = '0;
      cov_d     = '0;
      ff_vec_d  = '0;
      ff_mask_d = '0;
      pass_d    = 1'b0;
    end else if (s1_valid_q) begin
      cov_d[{s1_a_q, s1_b_q}] = 1'b1;
      if (mismatch != 7'd0) begin
        if (err_q != ERR_MAX) err_d = err_q + CNT_W'(1);
        // A failing sample always has a nonzero mask, so a zero mask means nothing captured yet
        if (ff_mask_q == 7'd0) begin
          ff_vec_d  = {s1_a_q, s1_b_q};
          ff_mask_d = mismatch;
        end
      end
    end

    if ((state_q == DRAIN) && (state_d == DONE)) begin
      pass_d = (err_q == '0) && (cov_q == 4'hF);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_a_q     <= 1'b0;
      s1_b_q     <= 1'b0;
      s1_y_q     <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      cov_q      <= '0;
      ff_vec_q   <= '0;
      ff_mask_q  <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_y_q     <= s1_y_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      cov_q      <= cov_d;
      ff_vec_q   <= ff_vec_d;
      ff_mask_q  <= ff_mask_d;
      pass_q     <= pass_d;
    end
  end

  assign busy_out            = (state_q == RUN) || (state_q == DRAIN);
  assign done_out            = (state_q == DONE);
  assign pass_out            = pass_q;
  assign err_count_out       = err_q;
  assign sample_count_out    = cnt_q;
  assign coverage_out        = cov_q;
  assign first_fail_vec_out  = ff_vec_q;
  assign first_fail_mask_out = ff_mask_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Table-driven bench for gate_result_checker: three full runs from a vector table plus
// hand-written reset, gap/ignore and mid-run-reset sequences.
module tb_gate_result_checker;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             start_in;
  logic             sample_valid_in;
  logic             a_in;
  logic             b_in;
  logic [6:0]       y_in;
  logic             busy_out;
  logic             done_out;
  logic             pass_out;
  logic [CNT_W-1:0] err_count_out;
  logic [CNT_W-1:0] sample_count_out;
  logic [3:0]       coverage_out;
  logic [1:0]       first_fail_vec_out;
  logic [6:0]       first_fail_mask_out;

  int checks = 0;
  int passed = 0;

  always #5 clk_in = ~clk_in;

  gate_result_checker #(.NUM_VECTORS(4), .CNT_W(CNT_W)) dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .start_in            (start_in),
    .sample_valid_in     (sample_valid_in),
    .a_in                (a_in),
    .b_in                (b_in),
    .y_in                (y_in),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .pass_out            (pass_out),
    .err_count_out       (err_count_out),
    .sample_count_out    (sample_count_out),
    .coverage_out        (coverage_out),
    .first_fail_vec_out  (first_fail_vec_out),
    .first_fail_mask_out (first_fail_mask_out)
  );

  // Each record holds one sample and the cumulative results expected once it is checked
  typedef struct {
    logic       a;
    logic       b;
    logic [6:0] y;
    int         err;
    int         cov;
    int         vec;
    int         mask;
  } vec_t;

  vec_t tbl[12];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic a, input logic b, input logic [6:0] y);
    sample_valid_in = v;
    a_in            = a;
    b_in            = b;
    y_in            = y;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, int'(busy_out), 0);
    checkOutput({tag, "_done"}, int'(done_out), 0);
    checkOutput({tag, "_pass"}, int'(pass_out), 0);
    checkOutput({tag, "_err"},  int'(err_count_out), 0);
    checkOutput({tag, "_cnt"},  int'(sample_count_out), 0);
    checkOutput({tag, "_cov"},  int'(coverage_out), 0);
    checkOutput({tag, "_vec"},  int'(first_fail_vec_out), 0);
    checkOutput({tag, "_mask"}, int'(first_fail_mask_out), 0);
  endtask

  // Samples on consecutive cycles; results for sample k show up two falling edges after it is driven
  task automatic runTable(input int base, input int expPass);
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    checkOutput("clear_pass", int'(pass_out), 0);
    checkOutput("clear_cov", int'(coverage_out), 0);
    checkOutput("clear_err", int'(err_count_out), 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk_in);
      checkOutput("run_busy", int'(busy_out), 1);
      checkOutput("run_done", int'(done_out), 0);
      checkOutput("run_count", int'(sample_count_out), (k > 4) ? 4 : k);
      if (k >= 2) begin
        checkOutput("run_err",  int'(err_count_out),       tbl[base+k-2].err);
        checkOutput("run_cov",  int'(coverage_out),        tbl[base+k-2].cov);
        checkOutput("run_vec",  int'(first_fail_vec_out),  tbl[base+k-2].vec);
        checkOutput("run_mask", int'(first_fail_mask_out), tbl[base+k-2].mask);
      end
      if (k < 4) applyStimulus(1'b1, tbl[base+k].a, tbl[base+k].b, tbl[base+k].y);
      else       applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
    end
    @(negedge clk_in);
    checkOutput("end_done", int'(done_out), 1);
    checkOutput("end_busy", int'(busy_out), 0);
    checkOutput("end_pass", int'(pass_out), expPass);
    @(negedge clk_in);
    checkOutput("post_done", int'(done_out), 0);
    checkOutput("hold_pass", int'(pass_out), expPass);
    checkOutput("hold_count", int'(sample_count_out), 4);
  endtask

  int gaps[4] = '{0, 0, 2, 3};
  int donePulses;

  initial begin
    // Clean exhaustive run
    tbl[0]  = '{1'b0, 1'b0, 7'b1101100, 0, 4'b0001, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 7'b1010110, 0, 4'b0011, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 7'b0010110, 0, 4'b0111, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 7'b0100011, 0, 4'b1111, 0, 0};
    // Single fault on 10: AND bit wrong
    tbl[4]  = '{1'b0, 1'b0, 7'b1101100, 0, 4'b0001, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 7'b1010110, 0, 4'b0011, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 7'b0010111, 1, 4'b0111, 2'b10, 7'b0000001};
    tbl[7]  = '{1'b1, 1'b1, 7'b0100011, 1, 4'b1111, 2'b10, 7'b0000001};
    // Two faults: 01 AND wrong, then 11 XNOR wrong must not overwrite the capture
    tbl[8]  = '{1'b0, 1'b0, 7'b1101100, 0, 4'b0001, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 7'b1010111, 1, 4'b0011, 2'b01, 7'b0000001};
    tbl[10] = '{1'b1, 1'b0, 7'b0010110, 1, 4'b0111, 2'b01, 7'b0000001};
    tbl[11] = '{1'b1, 1'b1, 7'b0000011, 2, 4'b1111, 2'b01, 7'b0000001};

    rst_n_in = 1'b0;
    start_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
    #3;
    checkAllZero("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Valids without a start must be ignored
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 7'b1101100);
      @(negedge clk_in);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
    @(negedge clk_in);
    checkOutput("idle_count", int'(sample_count_out), 0);
    checkOutput("idle_busy", int'(busy_out), 0);
    checkOutput("idle_cov", int'(coverage_out), 0);

    runTable(0, 1);
    runTable(4, 0);
    runTable(8, 0);

    // Gaps, start while busy, a valid during DRAIN, start while DONE
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        start_in = (i == 2 && g == 0);
        @(negedge clk_in);
      end
      start_in = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 7'b1101100);
      @(negedge clk_in);
    end
    checkOutput("drain_busy", int'(busy_out), 1);
    start_in = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 7'b0100011);
    donePulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      if (done_out) begin
        donePulses++;
        start_in = 1'b1;
      end else begin
        start_in = 1'b0;
      end
    end
    start_in = 1'b0;
    @(negedge clk_in);
    checkOutput("gap_done_pulses", donePulses, 1);
    checkOutput("gap_count", int'(sample_count_out), 4);
    checkOutput("gap_cov", int'(coverage_out), 4'b0001);
    checkOutput("gap_err", int'(err_count_out), 0);
    checkOutput("gap_pass", int'(pass_out), 0);
    checkOutput("gap_busy", int'(busy_out), 0);

    // Reset in the middle of a run after two accepted samples
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 7'b1101100);
    @(negedge clk_in);
    applyStimulus(1'b1, 1'b0, 1'b1, 7'b1010111);
    @(negedge clk_in);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
    @(negedge clk_in);
    checkOutput("mid_count", int'(sample_count_out), 2);
    checkOutput("mid_err", int'(err_count_out), 1);
    checkOutput("mid_busy", int'(busy_out), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checkAllZero("after_reset");
    runTable(0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
